// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared IO constants for the switch debouncer
//
// Purpose: IO address map for the switch/event/display ports, readback field
// offsets, default debounce window, and the event-clear decode helper used by
// the system top-level to build CLR_EVT from IOAddr/IOWriteEn.
// Ports: none (package).
package input_debouncer_pkg;

  // IO address map seen by the MIPS core.
  typedef enum logic [3:0] {
    IO_ADDR_SW_READ   = 4'h0,
    IO_ADDR_EVT_CLEAR = 4'h1,
    IO_ADDR_DISPLAY   = 4'h2
  } io_addr_e;

  // Readback word layout: stable levels from bit 0, change flags from bit 16.
  localparam int RD_W    = 32;
  localparam int STB_LSB = 0;
  localparam int EVT_LSB = 16;
  localparam int MAX_W   = 16;

  // 65536 cycles at 10 MHz is about 6.55 ms; 17 bits hold 0..65535.
  localparam int DEFAULT_STABLE_CYCLES = 65536;
  localparam int DEFAULT_CNT_W         = 17;

  // An IO write to the event-clear address produces the one-cycle CLR_EVT pulse.
  function automatic logic is_evt_clear(input logic [3:0] io_addr,
                                        input logic       io_write_en);
    return io_write_en && (io_addr == IO_ADDR_EVT_CLEAR);
  endfunction

endpackage

// File: rtl/input_debouncer_bit.sv
// rtl/input_debouncer_bit.sv - one-bit synchronizer, stability counter and event flag
//
// Purpose: debounce one raw switch level. Module name: debounce_bit.
// Ports:
//   CLK      in   system clock
//   RESET    in   asynchronous active-high reset
//   sw_in    in   raw asynchronous switch level
//   clr_evt  in   clears the sticky change flag
//   stable   out  debounced level
//   evt      out  sticky flag, set when stable changes
module debounce_bit #(
  parameter int STABLE_CYCLES = 65536,
  parameter int CNT_W         = 17
) (
  input  logic CLK,
  input  logic RESET,
  input  logic sw_in,
  input  logic clr_evt,
  output logic stable,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  // Two-flop synchronizer; sw_in is asynchronous to CLK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  assign differs = (s2 != stable);
  // The edge on which the counter already reads STABLE_CYCLES-1 is the
  // STABLE_CYCLES-th consecutive differing sample, so the new level is taken.
  assign accept  = differs && (cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt    <= '0;
      stable <= 1'b0;
      evt    <= 1'b0;
    end else begin
      if (!differs) begin
        // Any return to the accepted level restarts the full window.
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // A new change outranks a simultaneous clear so no edge is lost.
      if (accept) begin
        evt <= 1'b1;
      end else if (clr_evt) begin
        evt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - debounced switch inputs with sticky change flags and IO readback
//
// Purpose: condition WIDTH raw slide switches for the MIPS IOReadData path.
// Ports:
//   CLK           in   10 MHz system clock
//   RESET         in   asynchronous active-high reset
//   SW_IN         in   raw switch levels
//   CLR_EVT       in   one-cycle pulse (event-clear IO write) clearing all flags
//   SW_STABLE     out  debounced levels
//   SW_EVT        out  sticky per-bit change flags
//   IO_READ_DATA  out  {SW_EVT at bit 16, SW_STABLE at bit 0}, other bits 0
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW_IN,
  input  logic             CLR_EVT,
  output logic [WIDTH-1:0] SW_STABLE,
  output logic [WIDTH-1:0] SW_EVT,
  output logic [RD_W-1:0]  IO_READ_DATA
);

  // Each bit runs its own window, so simultaneous changes are independent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .CLK     (CLK),
      .RESET   (RESET),
      .sw_in   (SW_IN[i]),
      .clr_evt (CLR_EVT),
      .stable  (SW_STABLE[i]),
      .evt     (SW_EVT[i])
    );
  end

  // Readback is a pure function of registered state: reads have no side effects.
  always_comb begin
    IO_READ_DATA                      = '0;
    IO_READ_DATA[STB_LSB +: WIDTH]    = SW_STABLE;
    IO_READ_DATA[EVT_LSB +: WIDTH]    = SW_EVT;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

  logic        CLK;
  logic        RESET;
  logic [1:0]  SW_IN;
  logic        CLR_EVT;
  logic [1:0]  SW_STABLE;
  logic [1:0]  SW_EVT;
  logic [31:0] IO_READ_DATA;

  int checks;
  int errors;

  input_debouncer #(
    .WIDTH         (2),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SW_IN        (SW_IN),
    .CLR_EVT      (CLR_EVT),
    .SW_STABLE    (SW_STABLE),
    .SW_EVT       (SW_EVT),
    .IO_READ_DATA (IO_READ_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    RESET   = 1'b1;
    SW_IN   = 2'b11;
    CLR_EVT = 1'b0;

    // 1. Reset with switches high, then release and accept.
    #3;
    chk("rst_stable", {30'd0, SW_STABLE}, 32'h0);
    chk("rst_evt",    {30'd0, SW_EVT},    32'h0);
    chk("rst_rd",     IO_READ_DATA,       32'h0);
    tick(3);
    chk("rst_held_rd", IO_READ_DATA, 32'h0);
    RESET = 1'b0;
    tick(1);                                   // capture edge 0
    tick(4);
    chk("acc11_early", {30'd0, SW_STABLE}, 32'h0);
    tick(1);
    chk("acc11_stable", {30'd0, SW_STABLE}, 32'h3);
    chk("acc11_rd",     IO_READ_DATA,       32'h0003_0003);

    // Event clear; readback shows it the cycle after.
    CLR_EVT = 1'b1;
    tick(1);
    CLR_EVT = 1'b0;
    chk("clr_evt", {30'd0, SW_EVT}, 32'h0);
    chk("clr_rd",  IO_READ_DATA,    32'h0000_0003);

    // 6. Release path 11 -> 00.
    SW_IN = 2'b00;
    tick(1);
    tick(4);
    chk("rel_early", {30'd0, SW_STABLE}, 32'h3);
    tick(1);
    chk("rel_stable", {30'd0, SW_STABLE}, 32'h0);
    chk("rel_evt",    {30'd0, SW_EVT},    32'h3);
    chk("rel_rd",     IO_READ_DATA,       32'h0003_0000);

    CLR_EVT = 1'b1;
    tick(1);
    CLR_EVT = 1'b0;
    chk("clr2_rd", IO_READ_DATA, 32'h0);

    // 2. Glitch: bit 0 high for 3 cycles only.
    SW_IN = 2'b01;
    tick(3);
    SW_IN = 2'b00;
    tick(8);
    chk("glitch_stable", {30'd0, SW_STABLE}, 32'h0);
    chk("glitch_evt",    {30'd0, SW_EVT},    32'h0);

    // 3. Bounce on bit 1: 1/0/1 then hold 1.
    SW_IN = 2'b10;
    tick(1);
    SW_IN = 2'b00;
    tick(1);
    SW_IN = 2'b10;
    tick(1);                                   // last rising capture
    tick(4);
    chk("bounce_early", {30'd0, SW_STABLE}, 32'h0);
    tick(1);
    chk("bounce_stable", {30'd0, SW_STABLE}, 32'h2);
    chk("bounce_evt",    {30'd0, SW_EVT},    32'h2);

    // 4. Clear coincident with bit-0 acceptance: set wins on bit 0.
    SW_IN = 2'b11;
    tick(1);
    tick(4);
    chk("cvs_pre_evt",    {30'd0, SW_EVT},    32'h2);
    chk("cvs_pre_stable", {30'd0, SW_STABLE}, 32'h2);
    CLR_EVT = 1'b1;
    tick(1);
    CLR_EVT = 1'b0;
    chk("cvs_evt",    {30'd0, SW_EVT},    32'h1);
    chk("cvs_stable", {30'd0, SW_STABLE}, 32'h3);
    chk("cvs_rd",     IO_READ_DATA,       32'h0001_0003);

    // 5. Asynchronous reset, then reset in the middle of a count.
    SW_IN = 2'b00;
    RESET = 1'b1;
    #1;
    chk("async_rst_rd", IO_READ_DATA, 32'h0);
    tick(1);
    RESET = 1'b0;
    SW_IN = 2'b01;
    tick(3);
    chk("mid_cnt_pre", {29'd0, dut.g_bit[0].u_bit.cnt}, 32'h1);
    RESET = 1'b1;
    #1;
    chk("mid_cnt_rst", {29'd0, dut.g_bit[0].u_bit.cnt}, 32'h0);
    tick(1);
    RESET = 1'b0;
    tick(1);
    tick(4);
    chk("mid_early", {30'd0, SW_STABLE}, 32'h0);
    tick(1);
    chk("mid_stable", {30'd0, SW_STABLE}, 32'h1);
    chk("mid_rd",     IO_READ_DATA,       32'h0001_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
